nn_avalon_burst_master: RTL and testbench

- Avalon-MM burst master that drives the neural network SRAM slave port from the host/test side.
- Accepts simple word-transfer commands. Each command is a write (pixel/weight load, start trigger) or a read (result fetch).
- Splits each command into legal Avalon bursts, streams write data in and read data out, and reports completion with an error flag.
- Sits between the host command logic (or the bench driver) and the accelerator's write/read/beginbursttransfer/burstcount/address bus.

---
 rtl/nn_avalon_pkg.sv | 29 ++
 rtl/nn_burst_splitter.sv | 63 ++++++
 rtl/nn_avalon_burst_master.sv | 202 ++++++++++++++++++++
 tb/tb_nn_avalon_burst_master.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nn_avalon_pkg.sv
// Shared types and constants for the Avalon-MM burst master.
// Contents: FSM state encoding, Avalon response codes, default parameter
// values and a small response-classification helper.
package nn_avalon_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WR_BURST = 3'd1,
    RD_REQ   = 3'd2,
    RD_DATA  = 3'd3,
    DONE     = 3'd4
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam int DEF_ADDR_W    = 13;
  localparam int DEF_DATA_W    = 32;
  localparam int DEF_MAX_BURST = 256;
  localparam int DEF_BC_W      = 10;
  localparam int DEF_TIMEOUT   = 1024;
  localparam int LEN_W         = 16;

  // Anything other than OKAY is reported as an error.
  function automatic logic resp_is_error(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage

// File: rtl/nn_burst_splitter.sv
// Burst splitter shared by the write and read paths.
// Holds the words still to transfer and the current burst base address, and
// derives the size of the current burst.
// Ports:
//   clk, n_rst        clock, asynchronous active-low reset
//   load              capture a new command (load_base, load_len)
//   advance           current burst finished and more words remain
//   base              base address of the current burst
//   beats             min(remaining, MAX_BURST), stable for the whole burst
//   last              current burst is the final one of the command
module nn_burst_splitter
  import nn_avalon_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int BC_W      = DEF_BC_W,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [LEN_W-1:0]  load_len,
  input  logic              advance,
  output logic [ADDR_W-1:0] base,
  output logic [BC_W-1:0]   beats,
  output logic              last
);

  logic [LEN_W-1:0]  remaining_r;
  logic [ADDR_W-1:0] base_r;
  logic [ADDR_W-1:0] next_base_s;

  // Burst size and next base; the base wraps naturally at 2^ADDR_W.
  always_comb begin
    if (remaining_r > LEN_W'(MAX_BURST)) begin
      beats = BC_W'(MAX_BURST);
    end else begin
      beats = BC_W'(remaining_r);
    end
    last        = (remaining_r <= LEN_W'(MAX_BURST));
    next_base_s = base_r + ADDR_W'(beats);
    base        = base_r;
  end

  // remaining/base only change at command load or burst boundaries, so
  // beats and base are held for the whole burst.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      remaining_r <= '0;
      base_r      <= '0;
    end else if (load) begin
      remaining_r <= load_len;
      base_r      <= load_base;
    end else if (advance) begin
      remaining_r <= remaining_r - LEN_W'(beats);
      base_r      <= next_base_s;
    end else begin
      remaining_r <= remaining_r;
      base_r      <= base_r;
    end
  end

endmodule

// File: rtl/nn_avalon_burst_master.sv
// Avalon-MM burst master driving the neural-network SRAM slave port.
// Takes word-transfer commands (write or read, start address, length),
// splits them into bursts of at most MAX_BURST words, streams write data in
// and read data out, and pulses done/err at command end.
// Ports:
//   command side : cmd_valid/cmd_ready, cmd_write, cmd_address, cmd_len
//   write stream : wdata_valid, wdata, wdata_ready
//   read stream  : rdata_valid, rdata
//   completion   : done, err
//   Avalon bus   : write, read, beginbursttransfer, burstcount, address,
//                  writedata, readdata, readdatavalid, waitrequest, response
// MAX_BURST must not exceed 2^(BC_W-1).
module nn_avalon_burst_master
  import nn_avalon_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int MAX_BURST = DEF_MAX_BURST,
  parameter int BC_W      = DEF_BC_W,
  parameter int TIMEOUT   = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [15:0]       cmd_len,
  input  logic              wdata_valid,
  input  logic [DATA_W-1:0] wdata,
  output logic              wdata_ready,
  output logic              rdata_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              done,
  output logic              err,
  output logic              write,
  output logic              read,
  output logic              beginbursttransfer,
  output logic [BC_W-1:0]   burstcount,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] writedata,
  input  logic [DATA_W-1:0] readdata,
  input  logic              readdatavalid,
  input  logic              waitrequest,
  input  logic [1:0]        response
);

  localparam int TMO_W = $clog2(TIMEOUT) + 1;

  state_t            state_r;
  logic              err_r;
  logic              bbt_pend_r;
  logic [BC_W-1:0]   beat_cnt_r;
  logic [TMO_W-1:0]  tmo_r;
  logic [DATA_W-1:0] rdata_r;
  logic              rdata_valid_r;

  logic              in_wr_s;
  logic              in_rd_s;
  logic              wr_acc_s;
  logic              rd_beat_s;
  logic              beat_last_s;
  logic              burst_end_s;
  logic              advance_s;
  logic              load_s;
  logic [ADDR_W-1:0] base_s;
  logic [BC_W-1:0]   beats_s;
  logic              last_s;

  nn_burst_splitter #(
    .ADDR_W    (ADDR_W),
    .BC_W      (BC_W),
    .MAX_BURST (MAX_BURST)
  ) u_splitter (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (load_s),
    .load_base (cmd_address),
    .load_len  (cmd_len),
    .advance   (advance_s),
    .base      (base_s),
    .beats     (beats_s),
    .last      (last_s)
  );

  // Bus and handshake decode. write follows wdata_valid directly so a data
  // gap is a legal write gap; bbt_pend_r marks "first beat not yet shown",
  // so a stalled first beat keeps beginbursttransfer low after its first cycle.
  always_comb begin
    in_wr_s            = (state_r == WR_BURST);
    in_rd_s            = (state_r == RD_REQ) || (state_r == RD_DATA);
    write              = in_wr_s && wdata_valid;
    wr_acc_s           = write && !waitrequest;
    wdata_ready        = wr_acc_s;
    writedata          = in_wr_s ? wdata : '0;
    read               = (state_r == RD_REQ);
    beginbursttransfer = bbt_pend_r && (write || read);
    burstcount         = (in_wr_s || in_rd_s) ? beats_s : '0;
    address            = (in_wr_s || in_rd_s) ? base_s : '0;
    rd_beat_s          = (state_r == RD_DATA) && readdatavalid;
    beat_last_s        = (beat_cnt_r == (beats_s - BC_W'(1)));
    burst_end_s        = (wr_acc_s || rd_beat_s) && beat_last_s;
    advance_s          = burst_end_s && !last_s;
    load_s             = (state_r == IDLE) && cmd_valid;
    cmd_ready          = (state_r == IDLE);
    done               = (state_r == DONE);
    err                = (state_r == DONE) && err_r;
    rdata              = rdata_r;
    rdata_valid        = rdata_valid_r;
  end

  // Command FSM: burst sequencing, beat counting, timeout and sticky error.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_r       <= IDLE;
      err_r         <= 1'b0;
      bbt_pend_r    <= 1'b0;
      beat_cnt_r    <= '0;
      tmo_r         <= '0;
      rdata_r       <= '0;
      rdata_valid_r <= 1'b0;
    end else begin
      rdata_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            err_r      <= 1'b0;
            bbt_pend_r <= 1'b1;
            beat_cnt_r <= '0;
            tmo_r      <= '0;
            if (cmd_len == 16'd0) begin
              state_r <= DONE;
            end else if (cmd_write) begin
              state_r <= WR_BURST;
            end else begin
              state_r <= RD_REQ;
            end
          end
        end
        WR_BURST: begin
          if (write) begin
            bbt_pend_r <= 1'b0;
          end
          if (wr_acc_s) begin
            if (beat_last_s) begin
              beat_cnt_r <= '0;
              if (last_s) begin
                state_r <= DONE;
              end else begin
                bbt_pend_r <= 1'b1;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BC_W'(1);
            end
          end
        end
        RD_REQ: begin
          bbt_pend_r <= 1'b0;
          if (!waitrequest) begin
            state_r    <= RD_DATA;
            beat_cnt_r <= '0;
            tmo_r      <= '0;
          end
        end
        RD_DATA: begin
          // A beat arriving on the threshold cycle wins over the timeout.
          if (readdatavalid) begin
            rdata_r       <= readdata;
            rdata_valid_r <= 1'b1;
            tmo_r         <= '0;
            if (resp_is_error(response)) begin
              err_r <= 1'b1;
            end
            if (beat_last_s) begin
              beat_cnt_r <= '0;
              if (last_s) begin
                state_r <= DONE;
              end else begin
                state_r    <= RD_REQ;
                bbt_pend_r <= 1'b1;
              end
            end else begin
              beat_cnt_r <= beat_cnt_r + BC_W'(1);
            end
          end else if (tmo_r == TMO_W'(TIMEOUT - 1)) begin
            err_r   <= 1'b1;
            state_r <= DONE;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        DONE: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nn_avalon_burst_master.sv
// Self-checking bench for nn_avalon_burst_master. Expected bus beats, read
// words and completion flags are queued when each command is issued and
// popped by a negedge monitor as the DUT produces them.
module tb_nn_avalon_burst_master;

  localparam int ADDR_W    = 13;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 256;
  localparam int BC_W      = 10;
  localparam int TIMEOUT   = 1024;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [ADDR_W-1:0] addr;
    logic [BC_W-1:0]   bc;
  } wbeat_t;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [BC_W-1:0]   bc;
  } rreq_t;

  logic              clk = 1'b0;
  logic              n_rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [15:0]       cmd_len;
  logic              wdata_valid, wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic [DATA_W-1:0] rdata;
  logic              done, err;
  logic              write, read, beginbursttransfer;
  logic [BC_W-1:0]   burstcount;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] writedata, readdata;
  logic              readdatavalid, waitrequest;
  logic [1:0]        response;

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int bbt_cnt = 0;
  bit wr_phase = 1'b0;

  wbeat_t            exp_wr_q[$];
  rreq_t             exp_rq_q[$];
  logic [DATA_W-1:0] exp_rd_q[$];
  logic              exp_done_q[$];

  wbeat_t            m_wb;
  rreq_t             m_rq;
  logic [DATA_W-1:0] m_rd;
  logic              m_err;

  nn_avalon_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST),
    .BC_W(BC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_len(cmd_len),
    .wdata_valid(wdata_valid), .wdata(wdata), .wdata_ready(wdata_ready),
    .rdata_valid(rdata_valid), .rdata(rdata),
    .done(done), .err(err),
    .write(write), .read(read), .beginbursttransfer(beginbursttransfer),
    .burstcount(burstcount), .address(address), .writedata(writedata),
    .readdata(readdata), .readdatavalid(readdatavalid),
    .waitrequest(waitrequest), .response(response)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] wr_word(input logic [DATA_W-1:0] seed, input int i);
    return seed + DATA_W'(i);
  endfunction

  function automatic logic [DATA_W-1:0] rd_word(input int i);
    return DATA_W'(32'h11 * (i + 1));
  endfunction

  function automatic logic [BC_W-1:0] burst_len(input int len, input int b);
    int left;
    left = len - b * MAX_BURST;
    return BC_W'((left > MAX_BURST) ? MAX_BURST : left);
  endfunction

  // Scoreboard monitor: compares every bus beat, read word and completion.
  always @(negedge clk) begin
    if (beginbursttransfer) bbt_cnt++;
    if (wr_phase && !wdata_valid) chk_val("write_gap", 64'(write), 64'(1'b0));
    if (write && !waitrequest) begin
      if (exp_wr_q.size() == 0) begin
        chk_val("wr_unexpected", 64'(1'b1), 64'(1'b0));
      end else begin
        m_wb = exp_wr_q.pop_front();
        chk_val("wr_data", 64'(writedata), 64'(m_wb.data));
        chk_val("wr_addr", 64'(address), 64'(m_wb.addr));
        chk_val("wr_bc", 64'(burstcount), 64'(m_wb.bc));
      end
    end
    if (read && !waitrequest) begin
      if (exp_rq_q.size() == 0) begin
        chk_val("rq_unexpected", 64'(1'b1), 64'(1'b0));
      end else begin
        m_rq = exp_rq_q.pop_front();
        chk_val("rq_addr", 64'(address), 64'(m_rq.addr));
        chk_val("rq_bc", 64'(burstcount), 64'(m_rq.bc));
      end
    end
    if (rdata_valid) begin
      if (exp_rd_q.size() == 0) begin
        chk_val("rd_unexpected", 64'(1'b1), 64'(1'b0));
      end else begin
        m_rd = exp_rd_q.pop_front();
        chk_val("rd_data", 64'(rdata), 64'(m_rd));
      end
    end
    if (done) begin
      if (exp_done_q.size() == 0) begin
        chk_val("done_unexpected", 64'(1'b1), 64'(1'b0));
      end else begin
        m_err = exp_done_q.pop_front();
        chk_val("done_err", 64'(err), 64'(m_err));
      end
    end
  end

  // Offer one command; returns at posedge+1 right after it was accepted.
  task automatic issue(input bit wr, input logic [ADDR_W-1:0] a, input int len);
    cmd_valid   = 1'b1;
    cmd_write   = wr;
    cmd_address = a;
    cmd_len     = 16'(len);
    @(negedge clk);
    chk_val("cmd_ready_idle", 64'(cmd_ready), 64'(1'b1));
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [ADDR_W-1:0] addr, input int len,
                           input logic [DATA_W-1:0] seed, input bit gaps,
                           input bit rwait, input int abort_cyc);
    int  sent, last_acc, done_c, nb;
    bit  got_done, aborted;
    wbeat_t e;
    bbt_cnt = 0;
    nb = (len + MAX_BURST - 1) / MAX_BURST;
    for (int i = 0; i < len; i++) begin
      e.data = wr_word(seed, i);
      e.addr = ADDR_W'(int'(addr) + (i / MAX_BURST) * MAX_BURST);
      e.bc   = burst_len(len, i / MAX_BURST);
      exp_wr_q.push_back(e);
    end
    if (abort_cyc == 0) exp_done_q.push_back(1'b0);
    issue(1'b1, addr, len);
    sent = 0; last_acc = -1; done_c = -1; got_done = 1'b0; aborted = 1'b0;
    wr_phase = 1'b1;
    for (int k = 0; k < len * 4 + 64 && !got_done; k++) begin
      if (abort_cyc > 0 && k == abort_cyc) begin
        n_rst = 1'b0;
        #1;
        chk_val("rst_write", 64'(write), 64'(1'b0));
        chk_val("rst_read", 64'(read), 64'(1'b0));
        chk_val("rst_bbt", 64'(beginbursttransfer), 64'(1'b0));
        chk_val("rst_done", 64'(done), 64'(1'b0));
        chk_val("rst_cmd_ready", 64'(cmd_ready), 64'(1'b1));
        chk_val("rst_mid_burst", 64'(sent > 0 && sent < len), 64'(1'b1));
        wr_phase    = 1'b0;
        wdata_valid = 1'b0;
        waitrequest = 1'b0;
        exp_wr_q.delete();
        repeat (2) @(posedge clk);
        #3 n_rst = 1'b1;
        @(posedge clk); #1;
        chk_val("post_rst_ready", 64'(cmd_ready), 64'(1'b1));
        aborted = 1'b1;
        break;
      end
      wdata_valid = (sent < len) && (!gaps || (k % 2 == 0));
      wdata       = wr_word(seed, sent);
      waitrequest = rwait ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      if (k == 0) chk_val("cmd_ready_busy", 64'(cmd_ready), 64'(1'b0));
      if (wdata_valid && wdata_ready) begin
        sent++;
        last_acc = cyc;
      end
      if (done) begin
        got_done = 1'b1;
        done_c   = cyc;
      end
      @(posedge clk); #1;
    end
    wr_phase    = 1'b0;
    wdata_valid = 1'b0;
    waitrequest = 1'b0;
    if (!aborted) begin
      chk_val("wr_done_seen", 64'(got_done), 64'(1'b1));
      chk_val("wr_beats", 64'(sent), 64'(len));
      chk_val("wr_bbt_count", 64'(bbt_cnt), 64'(nb));
      chk_val("wr_q_drained", 64'(exp_wr_q.size()), 64'(0));
      if (len > 0) chk_val("wr_done_latency", 64'(done_c), 64'(last_acc + 1));
    end
  endtask

  task automatic run_read(input logic [ADDR_W-1:0] addr, input int len,
                          input int wait_c, input bit gap, input int err_beat,
                          input bit silent);
    int  pending, idx, hs_edge, done_c, nb;
    bit  got_done;
    rreq_t r;
    bbt_cnt = 0;
    nb = (len + MAX_BURST - 1) / MAX_BURST;
    for (int b = 0; b < nb; b++) begin
      r.addr = ADDR_W'(int'(addr) + b * MAX_BURST);
      r.bc   = burst_len(len, b);
      exp_rq_q.push_back(r);
    end
    if (!silent) for (int i = 0; i < len; i++) exp_rd_q.push_back(rd_word(i));
    exp_done_q.push_back(silent || (err_beat >= 0 && err_beat < len));
    issue(1'b0, addr, len);
    pending = 0; idx = 0; hs_edge = 0; done_c = 0; got_done = 1'b0;
    for (int k = 0; k < len * 4 + TIMEOUT + 64 && !got_done; k++) begin
      waitrequest = (k < wait_c);
      if (!silent && pending > 0 && (!gap || (k % 2 == 1))) begin
        readdatavalid = 1'b1;
        readdata      = rd_word(idx);
        response      = (idx == err_beat) ? 2'b10 : 2'b00;
        idx++;
        pending--;
      end else begin
        readdatavalid = 1'b0;
        response      = 2'b00;
      end
      @(negedge clk);
      if (read && !waitrequest) begin
        pending += int'(burstcount);
        hs_edge = cyc + 1;
      end
      if (done) begin
        got_done = 1'b1;
        done_c   = cyc;
      end
      @(posedge clk); #1;
    end
    readdatavalid = 1'b0;
    waitrequest   = 1'b0;
    chk_val("rd_done_seen", 64'(got_done), 64'(1'b1));
    chk_val("rd_bbt_count", 64'(bbt_cnt), 64'(nb));
    chk_val("rq_q_drained", 64'(exp_rq_q.size()), 64'(0));
    chk_val("rd_q_drained", 64'(exp_rd_q.size()), 64'(0));
    if (silent) begin
      chk_val("timeout_cycles", 64'(done_c - hs_edge), 64'(TIMEOUT));
      readdatavalid = 1'b1;
      readdata      = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      readdatavalid = 1'b0;
      @(negedge clk);
      chk_val("stray_ignored", 64'(rdata_valid), 64'(1'b0));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    n_rst = 1'b0;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_len = '0;
    wdata_valid = 1'b0; wdata = '0;
    readdata = '0; readdatavalid = 1'b0; waitrequest = 1'b0; response = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    chk_val("reset_cmd_ready", 64'(cmd_ready), 64'(1'b1));
    chk_val("reset_write", 64'(write), 64'(1'b0));
    chk_val("reset_read", 64'(read), 64'(1'b0));
    chk_val("reset_bbt", 64'(beginbursttransfer), 64'(1'b0));
    chk_val("reset_done", 64'(done), 64'(1'b0));
    chk_val("reset_rdata_valid", 64'(rdata_valid), 64'(1'b0));
    chk_val("reset_address", 64'(address), 64'(0));
    chk_val("reset_burstcount", 64'(burstcount), 64'(0));
    n_rst = 1'b1;
    @(posedge clk); #1;

    run_write(13'h100, 4, 32'h0000_00A0, 1'b0, 1'b0, 0);
    run_write(13'h000, 600, 32'h5A00_0000, 1'b0, 1'b0, 0);
    run_read(13'h1FFE, 3, 2, 1'b1, -1, 1'b0);
    run_read(13'h1FFF, 300, 0, 1'b0, -1, 1'b0);
    run_write(13'h0123, 40, 32'h3C00_1000, 1'b1, 1'b1, 0);
    run_read(13'h0200, 2, 0, 1'b0, 1, 1'b0);
    run_read(13'h0300, 2, 0, 1'b0, -1, 1'b1);
    run_write(13'h0777, 0, 32'h0, 1'b0, 1'b0, 0);
    run_write(13'h0040, 16, 32'h7700_0000, 1'b0, 1'b0, 6);
    run_write(13'h0080, 4, 32'h1234_0000, 1'b0, 1'b0, 0);

    chk_val("done_q_drained", 64'(exp_done_q.size()), 64'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
